// File: rtl/mem_rom_arbiter.sv
// Two-port (fetch/load) arbiter in front of a combinational program ROM, 1-cycle response latency.
// Default build: fixed priority plus load starvation counter; define ROM_ARB_RR_EN for round-robin.
module mem_rom_arbiter #(
  parameter int          ROM_WORDS  = 512,
  parameter int          STARVE_MAX = 3,
  parameter logic [31:0] NOP_WORD   = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  input  logic        if_flush,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  output logic        ld_gnt,
  output logic        ld_rvalid,
  output logic [31:0] ld_rdata,
  output logic        ld_err,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data
);

  logic [31:0] rom_addr_q;
  logic [31:0] gnt_addr;
  logic        err_d;
  logic [31:0] data_d;

`ifdef ROM_ARB_RR_EN
  // Last-grant pointer: 1 = load was granted last.
  logic last_ld_q;

  assign if_gnt = !reset && if_req && (!ld_req || last_ld_q);
  assign ld_gnt = !reset && ld_req && !if_gnt;

  always_ff @(posedge clk) begin
    if (reset)       last_ld_q <= 1'b1;
    else if (if_gnt) last_ld_q <= 1'b0;
    else if (ld_gnt) last_ld_q <= 1'b1;
  end
`else
  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ld_force;

  assign ld_force = (cnt_q == CW'(STARVE_MAX));
  assign if_gnt   = !reset && if_req && !(ld_req && ld_force);
  assign ld_gnt   = !reset && ld_req && !if_gnt;

  always_comb begin
    cnt_d = cnt_q;
    if (!ld_req || ld_gnt)          cnt_d = '0;
    else if (cnt_q != CW'(STARVE_MAX)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`endif

  assign gnt_addr = if_gnt ? if_addr : ld_addr;

  always_comb begin
    rom_addr = rom_addr_q;
    if (reset)       rom_addr = '0;
    else if (if_gnt) rom_addr = if_addr;
    else if (ld_gnt) rom_addr = ld_addr;
  end

  assign err_d  = (gnt_addr[1:0] != 2'b00) || ({2'b00, gnt_addr[31:2]} >= 32'(ROM_WORDS));
  assign data_d = err_d ? NOP_WORD : rom_data;

  always_ff @(posedge clk) begin
    if (reset) rom_addr_q <= '0;
    else       rom_addr_q <= rom_addr;
  end

  // Fetch side: staged response is only exposed if no flush arrives in the
  // response cycle; the hold registers keep the last value actually shown.
  logic        if_stg_vld_q, if_stg_err_q, if_hold_err_q;
  logic [31:0] if_stg_data_q, if_hold_data_q;

  assign if_rvalid = !reset && if_stg_vld_q && !if_flush;
  assign if_rdata  = reset ? '0 : (if_rvalid ? if_stg_data_q : if_hold_data_q);
  assign if_err    = reset ? 1'b0 : (if_rvalid ? if_stg_err_q : if_hold_err_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      if_stg_vld_q   <= 1'b0;
      if_stg_data_q  <= '0;
      if_stg_err_q   <= 1'b0;
      if_hold_data_q <= '0;
      if_hold_err_q  <= 1'b0;
    end else begin
      if_stg_vld_q   <= if_gnt && !if_flush;
      if_hold_data_q <= if_rdata;
      if_hold_err_q  <= if_err;
      if (if_gnt) begin
        if_stg_data_q <= data_d;
        if_stg_err_q  <= err_d;
      end
    end
  end

  logic        ld_rvalid_q, ld_err_q;
  logic [31:0] ld_rdata_q;

  assign ld_rvalid = !reset && ld_rvalid_q;
  assign ld_rdata  = reset ? '0 : ld_rdata_q;
  assign ld_err    = !reset && ld_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ld_rvalid_q <= 1'b0;
      ld_rdata_q  <= '0;
      ld_err_q    <= 1'b0;
    end else begin
      ld_rvalid_q <= ld_gnt;
      if (ld_gnt) begin
        ld_rdata_q <= data_d;
        ld_err_q   <= err_d;
      end
    end
  end

endmodule

// File: tb/tb_mem_rom_arbiter.sv
// Directed bench for mem_rom_arbiter; ROM model returns 32'hC0DE0000 | word_index.
module tb_mem_rom_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_flush, ld_req;
  logic [31:0] if_addr, ld_addr;
  logic        if_gnt, if_rvalid, if_err, ld_gnt, ld_rvalid, ld_err;
  logic [31:0] if_rdata, ld_rdata, rom_addr, rom_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign rom_data = 32'hC0DE0000 | {16'h0, rom_addr[17:2]};

  mem_rom_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_flush(if_flush),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_gnt(ld_gnt),
    .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .ld_err(ld_err),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // advance one cycle: inputs change just after the edge, checks happen at the negedge
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, {30'h0, if_gnt, ld_gnt}, 32'h0);
    chk({tag, "_rv"}, {30'h0, if_rvalid, ld_rvalid}, 32'h0);
    chk({tag, "_err"}, {30'h0, if_err, ld_err}, 32'h0);
    chk({tag, "_ifd"}, if_rdata, 32'h0);
    chk({tag, "_ldd"}, ld_rdata, 32'h0);
    chk({tag, "_ra"}, rom_addr, 32'h0);
  endtask

  logic exp_if [5];

  initial begin
    reset = 1'b1; if_req = 1'b1; ld_req = 1'b1; if_flush = 1'b0;
    if_addr = 32'h8; ld_addr = 32'h4;
    step(); step(); smp();
    chk_all_zero("rst");
    step(); reset = 1'b0; if_req = 1'b0; ld_req = 1'b0;
    smp();
    chk_all_zero("post_rst");

    // single fetch
    step(); if_req = 1'b1; if_addr = 32'h8;
    smp();
    chk("sf_gnt", {30'h0, if_gnt, ld_gnt}, 32'h2);
    chk("sf_ra", rom_addr, 32'h8);
    step(); if_req = 1'b0;
    smp();
    chk("sf_rv", {31'h0, if_rvalid}, 32'h1);
    chk("sf_rd", if_rdata, 32'hC0DE0002);
    chk("sf_err", {31'h0, if_err}, 32'h0);
    step(); smp();
    chk("sf_rv0", {31'h0, if_rvalid}, 32'h0);
    chk("sf_hold", if_rdata, 32'hC0DE0002);
    chk("ra_hold", rom_addr, 32'h8);

    // both requests held continuously
`ifdef ROM_ARB_RR_EN
    exp_if = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_if = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`endif
    step(); if_req = 1'b1; if_addr = 32'h10; ld_req = 1'b1; ld_addr = 32'h20;
    for (int c = 0; c < 5; c++) begin
      smp();
      chk($sformatf("arb_c%0d", c + 1), {30'h0, if_gnt, ld_gnt}, {30'h0, exp_if[c], !exp_if[c]});
      chk($sformatf("arb_ra%0d", c + 1), rom_addr, exp_if[c] ? 32'h10 : 32'h20);
`ifndef ROM_ARB_RR_EN
      if (c == 4) begin
        chk("starve_ldrv", {31'h0, ld_rvalid}, 32'h1);
        chk("starve_ldrd", ld_rdata, 32'hC0DE0008);
      end
`endif
      step();
    end
    if_req = 1'b0; ld_req = 1'b0;

    // fetch to set a known if_rdata, then flush in the response cycle
    step(); if_req = 1'b1; if_addr = 32'h14;
    step(); if_addr = 32'hC;
    smp();
    chk("fl_pre_rd", if_rdata, 32'hC0DE0005);
    chk("fl_gnt", {31'h0, if_gnt}, 32'h1);
    step(); if_req = 1'b0; if_flush = 1'b1; ld_req = 1'b1; ld_addr = 32'h4;
    smp();
    chk("fl_rv", {31'h0, if_rvalid}, 32'h0);
    chk("fl_rd", if_rdata, 32'hC0DE0005);
    chk("fl_ldgnt", {31'h0, ld_gnt}, 32'h1);
    step(); if_flush = 1'b0; ld_req = 1'b0;
    smp();
    chk("fl_ldrv", {31'h0, ld_rvalid}, 32'h1);
    chk("fl_ldrd", ld_rdata, 32'hC0DE0001);
    chk("fl_rv2", {31'h0, if_rvalid}, 32'h0);

    // flush in the grant cycle: grant still happens, response dropped
    step(); if_req = 1'b1; if_addr = 32'h18; if_flush = 1'b1;
    smp();
    chk("flg_gnt", {31'h0, if_gnt}, 32'h1);
    step(); if_req = 1'b0; if_flush = 1'b0;
    smp();
    chk("flg_rv", {31'h0, if_rvalid}, 32'h0);
    chk("flg_rd", if_rdata, 32'hC0DE0005);

    // error responses and back-to-back loads
    step(); ld_req = 1'b1; ld_addr = 32'h6;
    step(); ld_addr = 32'h800;
    smp();
    chk("e6_rv", {31'h0, ld_rvalid}, 32'h1);
    chk("e6_err", {31'h0, ld_err}, 32'h1);
    chk("e6_rd", ld_rdata, 32'h00000013);
    step(); ld_addr = 32'h7FC;
    smp();
    chk("e800_err", {31'h0, ld_err}, 32'h1);
    chk("e800_rd", ld_rdata, 32'h00000013);
    step(); ld_req = 1'b0; if_req = 1'b1; if_addr = 32'h2;
    smp();
    chk("lastw_err", {31'h0, ld_err}, 32'h0);
    chk("lastw_rd", ld_rdata, 32'hC0DE01FF);
    step(); if_req = 1'b0;
    smp();
    chk("ife_rv", {31'h0, if_rvalid}, 32'h1);
    chk("ife_err", {31'h0, if_err}, 32'h1);
    chk("ife_rd", if_rdata, 32'h00000013);
    chk("ld_hold", ld_rdata, 32'hC0DE01FF);

    // reset in the cycle after a grant
    step(); if_req = 1'b1; if_addr = 32'h24;
    step(); if_req = 1'b0; reset = 1'b1;
    smp();
    chk_all_zero("mrst1");
    step(); smp();
    chk_all_zero("mrst2");
    step(); reset = 1'b0;
    smp();
    chk_all_zero("mrst_rel");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
